pat_velocity_estimator: RTL and testbench
=========================================

Name: pat_velocity_estimator

Overview:
Inverse of the paddle location updater. Takes successive packed paddle locations from the sensor/MCU path and derives the packed velocity word and direction bits in the format the location updater consumes. Sits between the location-sample source and the paddle-motion logic. Also emits zero velocity when samples stop arriving.

Parameters:
MAX_SPEED, 11'd64, per-axis magnitude clamp; applies to both x and y.
TIMEOUT_CYC, 24'd5_000_000, idle cycles in ARMED before zero velocity is forced.
CNT_W, 24, width of the timeout counter.

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-high (asserted = 1 despite the name)
sample_valid  input  1  one-cycle strobe; pat_location is valid this cycle
pat_location  input  22  packed location: x = [21:11], y = [10:0], both unsigned
pat_velocity  output  32  packed speed: |dx| = [30:20], |dy| = [14:4]; all other bits 0
direction_x  output  1  1 = x increasing
direction_y  output  1  1 = y decreasing (screen up)
vel_valid  output  1  one-cycle pulse; new pat_velocity/direction values are valid
sample_overrun  output  1  sticky flag; a sample was dropped

Behaviour:
- Reset, asynchronous with rst_n=1: state=EMPTY; prev_loc=0; cur_loc=0; timeout counter=0. Outputs: pat_velocity=0, direction_x=0, direction_y=0, vel_valid=0, sample_overrun=0.
- A reset asserted mid-operation discards every stored sample. No vel_valid pulse is produced for a sample in flight.
- States:
  - EMPTY (no reference sample): on sample_valid, capture prev_loc := pat_location, then go to ARMED.
  - ARMED: on sample_valid, capture cur_loc := pat_location, clear the counter, then go to COMPUTE. Otherwise increment the counter. When the counter reaches TIMEOUT_CYC-1, go to EMPTY for the next cycle. On that same edge drive pat_velocity=0 and vel_valid=1. Direction bits hold their values.
  - COMPUTE (exactly one cycle): register the outputs, pulse vel_valid=1, set prev_loc := cur_loc, then go to ARMED.
- Latency: sample accepted at edge k. Outputs and vel_valid update at edge k+1. vel_valid is high for exactly one cycle.
- Arithmetic (per axis, 11-bit unsigned fields):
  - d = cur - prev, computed as a 12-bit signed value.
  - mag = |d|, saturated to MAX_SPEED.
  - Bits [31], [19:15] and [3:0] of pat_velocity are always 0.
- Direction:
  - direction_x = 1 if cur_x > prev_x; 0 if cur_x < prev_x; holds its previous value if equal.
  - direction_y = 1 if cur_y < prev_y; 0 if cur_y > prev_y; holds its previous value if equal.
- Wrap-around: none. The delta is the true signed difference. Locations are never treated as modular.
- sample_valid during COMPUTE: the sample is ignored and sample_overrun is set to 1. sample_overrun clears only on reset.
- Timeout and sample_valid on the same edge in ARMED: the sample wins, and no zero-velocity pulse is produced.
- Between vel_valid pulses, pat_velocity and the direction bits hold their values.

Test Plan:
- Reset, then samples (x=100,y=200) and 3 cycles later (x=110,y=195) -> one cycle after the second strobe: vel_valid=1, pat_velocity[30:20]=10, [14:4]=5, other bits 0, direction_x=1, direction_y=1.
- Samples (x=500,y=10) then (x=0,y=700) with MAX_SPEED=64 -> both magnitudes =64, direction_x=0, direction_y=0. Extremes (x=2047) then (x=0) -> magnitude 64, no overflow.
- Samples with equal x, then with dx=+3 and dy=0 -> direction_y holds its prior value, and the x fields update correctly.
- ARMED with no samples, TIMEOUT_CYC=20 -> exactly 20 cycles after the last strobe: a vel_valid pulse with pat_velocity=0 and state EMPTY. The next sample produces no pulse; the one after that does.
- Back-to-back strobes on cycles k and k+1 -> the second is dropped, sample_overrun=1 until reset, and the next valid pair computes against the first sample.
- rst_n pulsed in the cycle between the capture and COMPUTE -> no vel_valid, all outputs 0, state EMPTY.

Source files
------------

// File: rtl/pat_velocity_estimator.sv
// pat_velocity_estimator
// Derives the packed paddle velocity word and direction bits from successive
// packed paddle location samples. Each pair of samples yields one vel_valid
// pulse. If no sample arrives for TIMEOUT_CYC cycles, a zero-velocity pulse is
// emitted and the estimator drops its reference sample.
module pat_velocity_estimator #(
    parameter logic [10:0]      MAX_SPEED   = 11'd64,
    parameter int               CNT_W       = 24,
    parameter logic [CNT_W-1:0] TIMEOUT_CYC = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,          // active-high despite the name
    input  logic        sample_valid,
    input  logic [21:0] pat_location,
    output logic [31:0] pat_velocity,
    output logic        direction_x,
    output logic        direction_y,
    output logic        vel_valid,
    output logic        sample_overrun
);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_ARMED   = 2'd1,
        S_COMPUTE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST = TIMEOUT_CYC - CNT_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_timeout;
    logic [21:0]       r_prev_loc;
    logic [21:0]       r_cur_loc;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_vel;
    logic              r_dir_x;
    logic              r_dir_y;
    logic              r_vel_valid;
    logic              r_overrun;

    logic signed [11:0] w_dx;
    logic signed [11:0] w_dy;
    logic [10:0]        w_mag_x;
    logic [10:0]        w_mag_y;

    // Absolute value of a signed delta, clamped to MAX_SPEED. Inputs are
    // differences of 11-bit unsigned values, so -2048 never occurs.
    function automatic logic [10:0] sat_mag(input logic signed [11:0] d);
        logic [11:0] a;
        a = (d < 0) ? 12'(-d) : 12'(d);
        if (a > {1'b0, MAX_SPEED})
            return MAX_SPEED;
        return a[10:0];
    endfunction

    // True signed differences; no modular wrap of screen coordinates.
    assign w_dx    = $signed({1'b0, r_cur_loc[21:11]}) - $signed({1'b0, r_prev_loc[21:11]});
    assign w_dy    = $signed({1'b0, r_cur_loc[10:0]})  - $signed({1'b0, r_prev_loc[10:0]});
    assign w_mag_x = sat_mag(w_dx);
    assign w_mag_y = sat_mag(w_dy);

    // State register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            r_state <= S_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic; a sample in ARMED takes priority over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (sample_valid)
                    w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (sample_valid) begin
                    w_state_nxt = S_COMPUTE;
                end else if (r_cnt == LP_LAST) begin
                    w_state_nxt = S_EMPTY;
                    w_timeout   = 1'b1;
                end
            end
            S_COMPUTE: begin
                w_state_nxt = S_ARMED;
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    // Sample capture, timeout counting and registered outputs.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_prev_loc  <= '0;
            r_cur_loc   <= '0;
            r_cnt       <= '0;
            r_vel       <= '0;
            r_dir_x     <= 1'b0;
            r_dir_y     <= 1'b0;
            r_vel_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_vel_valid <= 1'b0;
            case (r_state)
                S_EMPTY: begin
                    if (sample_valid) begin
                        r_prev_loc <= pat_location;
                        r_cnt      <= '0;
                    end
                end
                S_ARMED: begin
                    if (sample_valid) begin
                        r_cur_loc <= pat_location;
                        r_cnt     <= '0;
                    end else if (w_timeout) begin
                        r_cnt       <= '0;
                        r_vel       <= '0;
                        r_vel_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_COMPUTE: begin
                    r_vel       <= {1'b0, w_mag_x, 5'b0, w_mag_y, 4'b0};
                    r_vel_valid <= 1'b1;
                    r_prev_loc  <= r_cur_loc;
                    if (w_dx > 0)
                        r_dir_x <= 1'b1;
                    else if (w_dx < 0)
                        r_dir_x <= 1'b0;
                    // y grows downward on screen, so a shrinking y means "up".
                    if (w_dy < 0)
                        r_dir_y <= 1'b1;
                    else if (w_dy > 0)
                        r_dir_y <= 1'b0;
                    if (sample_valid)
                        r_overrun <= 1'b1;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign pat_velocity   = r_vel;
    assign direction_x    = r_dir_x;
    assign direction_y    = r_dir_y;
    assign vel_valid      = r_vel_valid;
    assign sample_overrun = r_overrun;

endmodule

// File: tb/tb_pat_velocity_estimator.sv
// Directed bench for pat_velocity_estimator with a short timeout (20 cycles).
module tb_pat_velocity_estimator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [21:0] pat_location;
    logic [31:0] pat_velocity;
    logic        direction_x;
    logic        direction_y;
    logic        vel_valid;
    logic        sample_overrun;

    int errors = 0;
    int checks = 0;

    pat_velocity_estimator #(
        .MAX_SPEED  (11'd64),
        .CNT_W      (24),
        .TIMEOUT_CYC(24'd20)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_valid  (sample_valid),
        .pat_location  (pat_location),
        .pat_velocity  (pat_velocity),
        .direction_x   (direction_x),
        .direction_y   (direction_y),
        .vel_valid     (vel_valid),
        .sample_overrun(sample_overrun)
    );

    always #5 clk = ~clk;

    // Packs expected magnitudes into the velocity word layout.
    function automatic logic [31:0] vel(input logic [10:0] mx, input logic [10:0] my);
        return {1'b0, mx, 5'b0, my, 4'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe; returns #1 after the edge that accepts the sample.
    task automatic send(input logic [10:0] x, input logic [10:0] y);
        @(negedge clk);
        sample_valid = 1'b1;
        pat_location = {x, y};
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic early;
        logic found;

        rst_n        = 1'b1;
        sample_valid = 1'b0;
        pat_location = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vel",     pat_velocity,   32'h0);
        check("rst_dx",      direction_x,    32'h0);
        check("rst_dy",      direction_y,    32'h0);
        check("rst_valid",   vel_valid,      32'h0);
        check("rst_overrun", sample_overrun, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;

        // Basic pair: (100,200) then (110,195) three cycles later.
        send(11'd100, 11'd200);
        check("first_no_pulse", vel_valid, 32'h0);
        step();
        step();
        send(11'd110, 11'd195);
        check("pre_pulse", vel_valid, 32'h0);
        step();
        check("p1_valid", vel_valid,    32'h1);
        check("p1_vel",   pat_velocity, 32'h00A0_0050);
        check("p1_dx",    direction_x,  32'h1);
        check("p1_dy",    direction_y,  32'h1);
        step();
        check("p1_pulse_len", vel_valid,    32'h0);
        check("p1_hold",      pat_velocity, 32'h00A0_0050);

        // Saturation: prev (110,195).
        send(11'd500, 11'd10);
        step();
        check("sat1_vel", pat_velocity, vel(11'd64, 11'd64));
        check("sat1_dy",  direction_y,  32'h1);
        send(11'd0, 11'd700);
        step();
        check("sat2_valid", vel_valid,    32'h1);
        check("sat2_vel",   pat_velocity, vel(11'd64, 11'd64));
        check("sat2_dx",    direction_x,  32'h0);
        check("sat2_dy",    direction_y,  32'h0);

        // Extremes: x 2047 then 0; y 700 -> 0 -> 0.
        send(11'd2047, 11'd0);
        step();
        check("ext1_vel", pat_velocity, vel(11'd64, 11'd64));
        check("ext1_dx",  direction_x,  32'h1);
        check("ext1_dy",  direction_y,  32'h1);
        send(11'd0, 11'd0);
        step();
        check("ext2_vel", pat_velocity, vel(11'd64, 11'd0));
        check("ext2_dx",  direction_x,  32'h0);
        check("ext2_dy_hold", direction_y, 32'h1);

        // Equal x, then dx=+3 with dy=0.
        send(11'd0, 11'd5);
        step();
        check("eqx_vel",     pat_velocity, vel(11'd0, 11'd5));
        check("eqx_dx_hold", direction_x,  32'h0);
        check("eqx_dy",      direction_y,  32'h0);
        send(11'd3, 11'd5);
        step();
        check("dx3_vel",     pat_velocity, vel(11'd3, 11'd0));
        check("dx3_dx",      direction_x,  32'h1);
        check("dx3_dy_hold", direction_y,  32'h0);

        // Let ARMED time out; bounded wait.
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (vel_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("to1_seen",    found,        32'h1);
        check("to1_vel",     pat_velocity, 32'h0);
        check("to1_dx_hold", direction_x,  32'h1);
        check("to1_dy_hold", direction_y,  32'h0);

        // From EMPTY: one sample, then exactly 20 cycles to the zero pulse.
        send(11'd7, 11'd7);
        check("to2_no_pulse", vel_valid, 32'h0);
        early = 1'b0;
        repeat (19) begin
            step();
            if (vel_valid) early = 1'b1;
        end
        check("to2_early", early, 32'h0);
        step();
        check("to2_valid", vel_valid,    32'h1);
        check("to2_vel",   pat_velocity, 32'h0);
        step();
        check("to2_len", vel_valid, 32'h0);
        send(11'd10, 11'd10);
        step();
        check("after_to_first", vel_valid, 32'h0);
        send(11'd13, 11'd6);
        step();
        check("after_to_valid", vel_valid,    32'h1);
        check("after_to_vel",   pat_velocity, vel(11'd3, 11'd4));
        check("after_to_dy",    direction_y,  32'h1);
        check("ovr_clear",      sample_overrun, 32'h0);

        // Back-to-back strobes: the second lands in COMPUTE and is dropped.
        @(negedge clk);
        sample_valid = 1'b1;
        pat_location = {11'd20, 11'd20};
        @(negedge clk);
        pat_location = {11'd1000, 11'd1000};
        @(negedge clk);
        sample_valid = 1'b0;
        #2;
        check("b2b_valid",   vel_valid,      32'h1);
        check("b2b_vel",     pat_velocity,   vel(11'd7, 11'd14));
        check("b2b_overrun", sample_overrun, 32'h1);
        send(11'd30, 11'd25);
        step();
        check("b2b_next_vel", pat_velocity,   vel(11'd10, 11'd5));
        check("b2b_next_dy",  direction_y,    32'h0);
        check("ovr_sticky",   sample_overrun, 32'h1);

        // Reset between capture and COMPUTE.
        send(11'd50, 11'd50);
        #2 rst_n = 1'b1;
        #2 rst_n = 1'b0;
        step();
        check("mr_valid",   vel_valid,      32'h0);
        check("mr_vel",     pat_velocity,   32'h0);
        check("mr_dx",      direction_x,    32'h0);
        check("mr_overrun", sample_overrun, 32'h0);
        send(11'd60, 11'd60);
        step();
        check("mr_empty_no_pulse", vel_valid, 32'h0);
        send(11'd61, 11'd60);
        step();
        check("mr_pair_valid", vel_valid,    32'h1);
        check("mr_pair_vel",   pat_velocity, vel(11'd1, 11'd0));
        check("mr_pair_dx",    direction_x,  32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
